// File: rtl/booth_radix4_sequencer_if.sv
// Handshake and result bundle for the radix-4 Booth multiplier sequencer.
// The master side requests a multiply. The slave side (the sequencer) returns status, the product and the Booth decode.
interface booth_radix4_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH/2+2)
);
  logic               start;
  logic               clear;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      count;
  logic               sel_times_two;
  logic               sel_subtract;
  logic               sel_zero;

  modport master (
    output start, clear, is_signed, multiplicand, multiplier,
    input  ready, busy, done, product, count,
           sel_times_two, sel_subtract, sel_zero
  );

  modport slave (
    input  start, clear, is_signed, multiplicand, multiplier,
    output ready, busy, done, product, count,
           sel_times_two, sel_subtract, sel_zero
  );
endinterface

// File: rtl/booth_radix4_sequencer.sv
// Sequential radix-4 Booth multiplier. It retires two multiplier bits per RUN cycle.
// Unsigned operands take one extra step because their zero-extension bit must also be consumed.
module booth_radix4_sequencer #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH/2+2)
) (
  input  logic                         clk,
  input  logic                         reset,
  booth_radix4_sequencer_if.slave      bus
);

  localparam int EW = WIDTH + 2;   // extended operand / shift register width
  localparam int AW = WIDTH + 3;   // accumulator width, headroom for +/-2M
  localparam logic [CW-1:0] N_SIGNED   = CW'(WIDTH/2);
  localparam logic [CW-1:0] N_UNSIGNED = CW'(WIDTH/2 + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q;
  logic [EW-1:0]      sr_q;
  logic [EW-1:0]      mcand_q;
  logic               q_m1_q;
  logic               signed_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] product_q;

  logic [CW-1:0]      n_steps;
  logic               step_en;
  logic [2:0]         triplet;
  logic               dec_sub, dec_two, dec_zero;
  logic [AW-1:0]      mcand_ext, mag, digit, sum;
  logic [AW-1:0]      acc_next;
  logic [EW-1:0]      sr_next;
  logic [2*WIDTH-1:0] product_sel;

  assign n_steps = signed_q ? N_SIGNED : N_UNSIGNED;
  // RUN lasts N+1 cycles. The last cycle only registers the product from the settled accumulator,
  // so there is no path from the adder into the product register.
  assign step_en = (state_q == RUN) && (count_q != n_steps);

  assign triplet  = {sr_q[1:0], q_m1_q};
  assign dec_sub  = triplet[2];
  assign dec_two  = ~(triplet[1] ^ triplet[0]);
  assign dec_zero = (triplet == 3'b000) || (triplet == 3'b111);

  assign mcand_ext = {mcand_q[EW-1], mcand_q};
  assign mag       = dec_two ? (mcand_ext << 1) : mcand_ext;
  assign digit     = dec_zero ? '0 : (dec_sub ? -mag : mag);
  assign sum       = acc_q + digit;
  assign acc_next  = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign sr_next   = {sum[1:0], sr_q[EW-1:2]};

  // A signed run consumes only WIDTH multiplier bits, so the two unconsumed extension bits still sit at the bottom of sr_q.
  assign product_sel = signed_q ? {acc_q[WIDTH-1:0], sr_q[EW-1:2]}
                                : {acc_q[WIDTH-3:0], sr_q};

  assign bus.ready         = (state_q == IDLE);
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.product       = product_q;
  assign bus.count         = count_q;
  assign bus.sel_subtract  = step_en & dec_sub;
  assign bus.sel_times_two = step_en & dec_two;
  assign bus.sel_zero      = step_en & dec_zero;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.clear)              state_d = IDLE;
        else if (count_q == n_steps) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registers are reset, including the datapath, so a start after reset behaves exactly like one after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sr_q      <= '0;
      mcand_q   <= '0;
      q_m1_q    <= 1'b0;
      signed_q  <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          acc_q    <= '0;
          q_m1_q   <= 1'b0;
          count_q  <= '0;
          signed_q <= bus.is_signed;
          sr_q     <= {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
          mcand_q  <= {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
        end
        RUN: if (!bus.clear) begin
          if (step_en) begin
            acc_q   <= acc_next;
            sr_q    <= sr_next;
            q_m1_q  <= sr_q[1];
            count_q <= count_q + CW'(1);
          end else begin
            product_q <= product_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_sequencer.sv
// Directed bench for booth_radix4_sequencer at WIDTH=8.
// It runs a vector table and then hand-written sequences for abort, reset and busy-start behaviour.
module tb_booth_radix4_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  booth_radix4_sequencer_if #(.WIDTH(8), .CW(3)) bus ();

  booth_radix4_sequencer #(.WIDTH(8), .CW(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle. Operands are scrambled after acceptance.
  task automatic run_mul(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat, input string name);
    int cyc;
    cyc = 0;
    bus.is_signed = sgn; bus.multiplicand = a; bus.multiplier = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.is_signed = ~sgn; bus.multiplicand = ~a; bus.multiplier = ~b;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin cyc = i; break; end
    end
    check($sformatf("%s.latency", name), cyc, lat);
    check($sformatf("%s.product", name), bus.product, exp);
    check($sformatf("%s.count", name), bus.count, lat - 1);
    @(posedge clk); #1;
    check($sformatf("%s.done_pulse", name), bus.done, 1'b0);
    check($sformatf("%s.ready_after", name), bus.ready, 1'b1);
  endtask

  initial begin
    int  cyc;
    bit  seen;

    vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 5, "s_m3x5"};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 6, "u_255x255"};
    vecs[2] = '{1'b1, 8'h80, 8'h80, 16'h4000, 5, "s_m128xm128"};
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 5, "s_127xm128"};
    vecs[4] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 5, "s_127x127"};
    vecs[5] = '{1'b0, 8'hC8, 8'h03, 16'h0258, 6, "u_200x3"};
    vecs[6] = '{1'b0, 8'h80, 8'h02, 16'h0100, 6, "u_128x2"};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 16'h0000, 5, "s_0xm1"};
    vecs[8] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 5, "s_m1xm1"};
    vecs[9] = '{1'b0, 8'hFF, 8'h01, 16'h00FF, 6, "u_255x1"};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.is_signed = 1'b0;
    bus.multiplicand = '0; bus.multiplier = '0;
    #3;
    check("reset.ready", bus.ready, 1'b1);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.done", bus.done, 1'b0);
    check("reset.product", bus.product, 16'h0000);
    check("reset.count", bus.count, 3'd0);
    check("reset.sel", {bus.sel_subtract, bus.sel_times_two, bus.sel_zero}, 3'b000);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle.ready", bus.ready, 1'b1);

    foreach (vecs[i]) run_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Booth decode: multiplier 0xFE gives triplet 100 (-2M) in the first step, then 111 (zero).
    check("sel.idle", {bus.sel_subtract, bus.sel_times_two, bus.sel_zero}, 3'b000);
    bus.is_signed = 1'b1; bus.multiplicand = 8'h03; bus.multiplier = 8'hFE; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("sel.step0", {bus.sel_subtract, bus.sel_times_two, bus.sel_zero}, 3'b110);
    @(posedge clk); #1;
    check("sel.step1", {bus.sel_subtract, bus.sel_times_two, bus.sel_zero}, 3'b111);
    cyc = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin cyc = i; break; end
    end
    check("sel.latency", cyc, 5);
    check("sel.product", bus.product, 16'hFFFA);
    @(posedge clk); #1;

    // Clear in the third RUN cycle: back to IDLE, no done, product keeps 0xFFFA.
    bus.is_signed = 1'b1; bus.multiplicand = 8'h55; bus.multiplier = 8'h33; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check("clear.ready", bus.ready, 1'b1);
    check("clear.busy", bus.busy, 1'b0);
    check("clear.done", bus.done, 1'b0);
    check("clear.product", bus.product, 16'hFFFA);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("clear.no_activity", seen, 1'b0);
    run_mul(1'b0, 8'd10, 8'd20, 16'h00C8, 6, "clear.next_op");

    // Start held high with changing operands while busy: only the first multiply completes.
    bus.is_signed = 1'b1; bus.multiplicand = 8'hF9; bus.multiplier = 8'h06; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.multiplicand = 8'($urandom); bus.multiplier = 8'($urandom); bus.is_signed = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) begin cyc = i; break; end
    end
    bus.start = 1'b0;
    check("busy_start.latency", cyc, 5);
    check("busy_start.product", bus.product, 16'hFFD6);
    @(posedge clk); #1;
    check("busy_start.ready", bus.ready, 1'b1);
    @(posedge clk); #1;
    check("busy_start.no_requeue", bus.busy, 1'b0);
    check("busy_start.product_hold", bus.product, 16'hFFD6);

    // Asynchronous reset in the middle of RUN, observed before any further clock edge.
    bus.is_signed = 1'b1; bus.multiplicand = 8'h40; bus.multiplier = 8'h40; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("midrun.busy_before", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrun.ready", bus.ready, 1'b1);
    check("midrun.busy", bus.busy, 1'b0);
    check("midrun.done", bus.done, 1'b0);
    check("midrun.product", bus.product, 16'h0000);
    check("midrun.count", bus.count, 3'd0);
    check("midrun.sel", {bus.sel_subtract, bus.sel_times_two, bus.sel_zero}, 3'b000);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(1'b0, 8'd7, 8'd9, 16'h003F, 6, "post_reset_7x9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
